// File: rtl/cr_crcgc_mc_pkg.sv
// Shared types and bit-order helpers for the multi-context CRC engine.
// Struct fields are sized for the widest supported configuration and narrowed by the users.
package cr_crcgc_mc_pkg;

  localparam int CRC_MAX_W = 64;
  localparam int CTX_MAX_W = 8;
  localparam logic [31:0] LEN_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [CRC_MAX_W-1:0] crc;
    logic [31:0]          len;
    logic                 active;
  } crcgc_mc_ctx_t;

  typedef struct packed {
    logic [CTX_MAX_W-1:0] ctx;
    logic [CRC_MAX_W-1:0] crc;
    logic [31:0]          len;
    logic                 good;
    logic                 err;
  } crcgc_mc_res_t;

  function automatic logic [7:0] reflect8(input logic [7:0] v);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[3'(7 - i)];
    end
    return r;
  endfunction

  // Mirrors the low w bits of v; bits at and above w come back as zero.
  function automatic logic [63:0] reflect_bits(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) begin
        r[i] = v[6'(w - 1 - i)];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cr_crcgc_mc_if.sv
// Beat input stream, result output stream and error event of the CRC engine.
// The slave modport is the engine side, the master modport the user side.
interface cr_crcgc_mc_if #(
  parameter int N_CTX  = 4,
  parameter int DATA_W = 64,
  parameter int CRC_W  = 32
);
  localparam int CTX_W = (N_CTX > 1) ? $clog2(N_CTX) : 1;
  localparam int NBW   = $clog2(DATA_W / 8) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CTX_W-1:0]  in_ctx;
  logic              in_sof;
  logic              in_eof;
  logic [DATA_W-1:0] in_data;
  logic [NBW-1:0]    in_nbytes;
  logic              in_chk_en;
  logic [CRC_W-1:0]  in_expect;

  logic              out_valid;
  logic              out_ready;
  logic [CTX_W-1:0]  out_ctx;
  logic [CRC_W-1:0]  out_crc;
  logic [31:0]       out_len;
  logic              out_good;
  logic              out_err;
  logic              ev_proto_err;

  modport slave (
    input  in_valid, in_ctx, in_sof, in_eof, in_data, in_nbytes, in_chk_en, in_expect,
    input  out_ready,
    output in_ready,
    output out_valid, out_ctx, out_crc, out_len, out_good, out_err, ev_proto_err
  );

  modport master (
    output in_valid, in_ctx, in_sof, in_eof, in_data, in_nbytes, in_chk_en, in_expect,
    output out_ready,
    input  in_ready,
    input  out_valid, out_ctx, out_crc, out_len, out_good, out_err, ev_proto_err
  );

endinterface

// File: rtl/cr_crcgc_mc_fold.sv
// Combinational fold of up to DATA_W/8 bytes into a CRC register kept in MSB-first form.
// Reflected modes mirror each input byte here and the whole register at the result stage.
module cr_crcgc_mc_fold
  import cr_crcgc_mc_pkg::*;
#(
  parameter int               DATA_W  = 64,
  parameter int               CRC_W   = 32,
  parameter logic [CRC_W-1:0] POLY    = 32'h04C11DB7,
  parameter bit               REFLECT = 1'b1,
  localparam int              NB      = DATA_W / 8,
  localparam int              NBW     = $clog2(NB) + 1
) (
  input  logic [CRC_W-1:0]  base_crc,
  input  logic [DATA_W-1:0] data,
  input  logic [NBW-1:0]    nbytes,
  output logic [CRC_W-1:0]  crc
);

  // Byte lanes below nbytes are folded in order, lane 0 first.
  always_comb begin
    logic [CRC_W-1:0] crc_v;
    logic [7:0]       byte_v;
    crc_v  = base_crc;
    byte_v = 8'd0;
    for (int i = 0; i < NB; i++) begin
      byte_v = REFLECT ? reflect8(data[8*i +: 8]) : data[8*i +: 8];
      if (NBW'(i) < nbytes) begin
        crc_v = crc_v ^ (CRC_W'(byte_v) << (CRC_W - 8));
        for (int b = 0; b < 8; b++) begin
          if (crc_v[CRC_W-1]) begin
            crc_v = (crc_v << 1) ^ POLY;
          end else begin
            crc_v = crc_v << 1;
          end
        end
      end else begin
        crc_v = crc_v;
      end
    end
    crc = crc_v;
  end

endmodule

// File: rtl/cr_crcgc_mc.sv
// Multi-context CRC generator/checker: per-context running CRC and length,
// one registered result per end-of-frame with optional compare.
module cr_crcgc_mc
  import cr_crcgc_mc_pkg::*;
#(
  parameter int               N_CTX   = 4,
  parameter int               DATA_W  = 64,
  parameter int               CRC_W   = 32,
  parameter logic [CRC_W-1:0] POLY    = 32'h04C11DB7,
  parameter logic [CRC_W-1:0] INIT    = 32'hFFFFFFFF,
  parameter logic [CRC_W-1:0] XOR_OUT = 32'hFFFFFFFF,
  parameter bit               REFLECT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  cr_crcgc_mc_if.slave  bus
);

  localparam int CTX_W = (N_CTX > 1) ? $clog2(N_CTX) : 1;
  localparam int NB    = DATA_W / 8;
  localparam int NBW   = $clog2(NB) + 1;
  localparam crcgc_mc_ctx_t CTX_IDLE = '{crc: CRC_MAX_W'(INIT), len: 32'd0, active: 1'b0};

  crcgc_mc_ctx_t ctx_r [N_CTX];
  crcgc_mc_res_t res_r;
  logic          out_valid_r;
  logic          proto_err_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             ctx_ok_s;
  logic [CTX_W-1:0] idx_s;
  crcgc_mc_ctx_t    cur_s;
  logic             fresh_s;
  logic [CRC_W-1:0] base_crc_s;
  logic [31:0]      base_len_s;
  logic [NBW-1:0]   n_s;
  logic [32:0]      len_sum_s;
  logic [31:0]      len_next_s;
  logic [CRC_W-1:0] crc_next_s;
  logic [63:0]      refl_s;
  logic [CRC_W-1:0] fin_s;
  logic             match_s;
  logic             proto_s;

  assign in_ready_s = ~out_valid_r | bus.out_ready;
  assign accept_s   = bus.in_valid & in_ready_s;

  // Context numbers beyond N_CTX only exist when N_CTX is not a power of two.
  generate
    if (N_CTX == (1 << CTX_W)) begin : g_ctx_full
      assign ctx_ok_s = 1'b1;
    end else begin : g_ctx_part
      assign ctx_ok_s = (bus.in_ctx < CTX_W'(N_CTX));
    end
  endgenerate

  assign idx_s = ctx_ok_s ? bus.in_ctx : '0;

  // Select the starting CRC/length for this beat and clamp the byte count.
  always_comb begin
    cur_s   = ctx_r[idx_s];
    fresh_s = bus.in_sof | ~cur_s.active;
    if (fresh_s) begin
      base_crc_s = INIT;
      base_len_s = 32'd0;
    end else begin
      base_crc_s = CRC_W'(cur_s.crc);
      base_len_s = cur_s.len;
    end
    if (bus.in_nbytes > NBW'(NB)) begin
      n_s = NBW'(NB);
    end else begin
      n_s = bus.in_nbytes;
    end
    len_sum_s = {1'b0, base_len_s} + 33'(n_s);
    if (len_sum_s[32]) begin
      len_next_s = LEN_MAX;
    end else begin
      len_next_s = len_sum_s[31:0];
    end
  end

  cr_crcgc_mc_fold #(
    .DATA_W  (DATA_W),
    .CRC_W   (CRC_W),
    .POLY    (POLY),
    .REFLECT (REFLECT)
  ) u_fold (
    .base_crc (base_crc_s),
    .data     (bus.in_data),
    .nbytes   (n_s),
    .crc      (crc_next_s)
  );

  // Final result: output reflection, XOR_OUT and the compare against in_expect.
  always_comb begin
    if (REFLECT) begin
      refl_s = reflect_bits(64'(crc_next_s), CRC_W);
    end else begin
      refl_s = 64'(crc_next_s);
    end
    fin_s   = CRC_W'(refl_s) ^ XOR_OUT;
    match_s = (fin_s == bus.in_expect);
    proto_s = accept_s & (~ctx_ok_s | (bus.in_sof & cur_s.active) | (~bus.in_sof & ~cur_s.active));
  end

  // Context array: write back mid-frame, return to idle on end-of-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CTX; i++) begin
        ctx_r[i] <= CTX_IDLE;
      end
    end else if (accept_s & ctx_ok_s) begin
      if (bus.in_eof) begin
        ctx_r[idx_s] <= CTX_IDLE;
      end else begin
        ctx_r[idx_s] <= '{crc: CRC_MAX_W'(crc_next_s), len: len_next_s, active: 1'b1};
      end
    end else begin
      ctx_r <= ctx_r;
    end
  end

  // Result register: reload on eof (even while the old result drains), hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      res_r       <= '0;
      proto_err_r <= 1'b0;
    end else begin
      proto_err_r <= proto_s;
      if (accept_s & ctx_ok_s & bus.in_eof) begin
        out_valid_r <= 1'b1;
        res_r       <= '{ctx:  CTX_MAX_W'(idx_s),
                         crc:  CRC_MAX_W'(fin_s),
                         len:  len_next_s,
                         good: bus.in_chk_en & match_s,
                         err:  bus.in_chk_en & ~match_s};
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
        res_r       <= res_r;
      end else begin
        out_valid_r <= out_valid_r;
        res_r       <= res_r;
      end
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_ctx      = CTX_W'(res_r.ctx);
  assign bus.out_crc      = CRC_W'(res_r.crc);
  assign bus.out_len      = res_r.len;
  assign bus.out_good     = res_r.good;
  assign bus.out_err      = res_r.err;
  assign bus.ev_proto_err = proto_err_r;

endmodule
